// File: rtl/rca_pkg.sv
// Shared definitions for the sequential arithmetic blocks: FSM state encoding.
package rca_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    FINISH = 2'b10
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: DIFF = A - B - BIN, BOUT set when a borrow is needed.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic BIN,
  output logic DIFF,
  output logic BOUT
);

  assign DIFF = A ^ B ^ BIN;
  assign BOUT = (~A & B) | (~(A ^ B) & BIN);

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: one bit per SHIFT cycle, LSB first, result published
// on DIFF/BOUT on the edge that enters FINISH. Back-to-back starts are
// accepted in FINISH, giving one result every WIDTH+1 cycles.
module serial_subtractor_4bit
  import rca_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BOUT
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             d_bit, br_nx;
  logic             last;
  logic             load;

  // Bit slice works on the current operand LSBs and the running borrow.
  full_subtractor u_fs (a_sh[0], b_sh[0], br, d_bit, br_nx);

  // The cycle processing the MSB is the last SHIFT cycle.
  assign last = (cnt == CNT_W'(WIDTH - 1));

  // Next-state decode; START is only honoured in IDLE or FINISH.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          state_nx = SHIFT;
          load     = 1'b1;
        end
      end
      SHIFT: begin
        if (last) state_nx = FINISH;
      end
      FINISH: begin
        if (START) begin
          state_nx = SHIFT;
          load     = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register; BUSY/DONE are registered from the next state so they
  // line up exactly with the SHIFT and FINISH cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= state_nx;
      BUSY  <= (state_nx == SHIFT);
      DONE  <= (state_nx == FINISH);
    end
  end

  // Operand capture, serial shift, and result publication on the last bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_sh <= '0;
      b_sh <= '0;
      br   <= 1'b0;
      res  <= '0;
      cnt  <= '0;
      DIFF <= '0;
      BOUT <= 1'b0;
    end else if (load) begin
      a_sh <= A;
      b_sh <= B;
      br   <= BIN;
      res  <= '0;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      br   <= br_nx;
      res  <= {d_bit, res[WIDTH-1:1]};
      cnt  <= cnt + CNT_W'(1);
      if (last) begin
        DIFF <= {d_bit, res[WIDTH-1:1]};
        BOUT <= br_nx;
      end
    end
  end

endmodule

// File: doc/serial_subtractor_4bit.md
SERIAL_SUBTRACTOR_4BIT -- requirements
Module: serial_subtractor_4bit

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-004 SHALL have port START  input  1  request to begin one subtraction.
REQ-005 SHALL have port A  input  WIDTH  minuend; sampled only on an accepted START.
REQ-006 SHALL have port B  input  WIDTH  subtrahend; sampled only on an accepted START.
REQ-007 SHALL have port BIN  input  1  borrow-in; sampled only on an accepted START.
REQ-008 SHALL have port BUSY  output  1  high while bits are being processed.
REQ-009 SHALL have port DONE  output  1  one-cycle pulse when DIFF/BOUT update.
REQ-010 SHALL have port DIFF  output  WIDTH  registered result, A - B - BIN mod 2^WIDTH.
REQ-011 SHALL have port BOUT  output  1  registered borrow-out; 1 iff A < B + BIN (unsigned).

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, FINISH.
REQ-013 SHALL accept START only in IDLE or FINISH; START in SHIFT SHALL be ignored with no effect.
REQ-014 On accepted START: load A, B into shift registers, BIN into borrow flop, bit counter = 0, next state SHIFT.
REQ-015 In SHIFT, each cycle SHALL subtract operand LSBs with the borrow flop (d = a^b^br; br' = (~a&b) | (~(a^b)&br)), shift d into result register at MSB, shift operands right, increment counter.
REQ-016 After the WIDTH-th SHIFT cycle SHALL go to FINISH, copying the result register to DIFF and the final borrow to BOUT on that edge.
REQ-017 DONE SHALL be high exactly during the FINISH cycle; BUSY SHALL be high exactly during SHIFT cycles.
REQ-018 Latency: START high at edge t → DONE high in the cycle after edge t+WIDTH (WIDTH+1 edges); throughput one result per WIDTH+1 cycles with back-to-back START.
REQ-019 FINISH without START SHALL return to IDLE; FINISH with START SHALL behave as REQ-014 (back-to-back).
REQ-020 DIFF and BOUT SHALL hold their last value from FINISH until the next FINISH; they SHALL NOT change during SHIFT.
REQ-021 Changes on A, B, BIN outside an accepted START SHALL not affect the operation in progress.

Reset
REQ-022 RST high at a rising edge SHALL force state IDLE, DIFF = 0, BOUT = 0, DONE = 0, BUSY = 0, internal registers and counter = 0.
REQ-023 RST SHALL take priority over START; RST during SHIFT SHALL abort with no DONE pulse and no DIFF/BOUT update.

Structure
REQ-024 State encodings (IDLE=2'b00, SHIFT=2'b01, FINISH=2'b10) SHALL reside in shared package/header rca_pkg, reused by future sequential arithmetic blocks.
REQ-025 The per-bit arithmetic SHALL be a separate combinational sub-module full_subtractor (ports A, B, BIN, DIFF, BOUT), instantiated once with positional port mapping.
REQ-026 Bit counter width SHALL be clog2(WIDTH)+1; no latches; all outputs registered.

Verification
REQ-027 A=4'd5, B=4'd3, BIN=0, START pulse → BUSY 4 cycles, DONE in 5th cycle, DIFF=4'b0010, BOUT=0.
REQ-028 A=4'd3, B=4'd5, BIN=0 → DIFF=4'b1110, BOUT=1; A=0, B=0, BIN=1 → DIFF=4'b1111, BOUT=1.
REQ-029 START held high throughout: results complete every 5 cycles; A/B changed mid-SHIFT, and START pulsed mid-SHIFT, leave the result unchanged.
REQ-030 RST asserted on 2nd SHIFT cycle of A=9, B=2 → no DONE, DIFF/BOUT = 0, BUSY=0 on next cycle; next START A=9, B=2 → DIFF=4'd7, BOUT=0.
REQ-031 START asserted in the FINISH cycle with A=15, B=15, BIN=1 → accepted, next DONE 5 cycles later with DIFF=4'b1111, BOUT=1.
REQ-032 Exhaustive sweep of all 512 (A, B, BIN) combinations → every {BOUT, DIFF} equals the 5-bit value of A - B - BIN computed in two's complement.
